// File: rtl/tdm_deframer_1_4.sv
// Serial TDM deframer: steers accepted bits round-robin to four channels, assembles one WIDTH-bit
// word per channel (MSB first) and publishes the whole frame on a valid/ready output register.
module tdm_deframer_1_4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic               in_valid,
    input  logic               frame_start,
    output logic [1:0]         sel,
    output logic [4*WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               overflow,
    output logic               sync_err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       shift_ch;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             shift_en;
    logic             restart;
    logic             complete;
    logic [WIDTH-1:0] shift_reg [4];
    logic [WIDTH-1:0] last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= CNT_TOP;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        shift_ch  = sel;
        shift_en  = 1'b0;
        restart   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && frame_start) begin
                    shift_en  = 1'b1;
                    shift_ch  = 2'd0;
                    state_nxt = RUN;
                    sel_nxt   = 2'd1;
                    cnt_nxt   = CNT_TOP;
                end
            end
            RUN: begin
                if (in_valid) begin
                    shift_en = 1'b1;
                    // Any frame_start seen here is mid-frame: restart with this bit as ch0 MSB.
                    if (frame_start) begin
                        restart  = 1'b1;
                        shift_ch = 2'd0;
                        sel_nxt  = 2'd1;
                        cnt_nxt  = CNT_TOP;
                    end else if (sel == 2'd3 && cnt == '0) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                        sel_nxt   = 2'd0;
                        cnt_nxt   = CNT_TOP;
                    end else begin
                        sel_nxt = sel + 2'd1;
                        if (sel == 2'd3) cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_word = {shift_reg[3][WIDTH-2:0], i};
    assign busy      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) shift_reg[c] <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (shift_en) shift_reg[shift_ch] <= {shift_reg[shift_ch][WIDTH-2:0], i};
            if (restart) sync_err <= 1'b1;
            if (complete) begin
                // A frame finishing on the handshake edge replaces the consumed one seamlessly.
                if (!out_valid || out_ready) begin
                    out_data  <= {last_word, shift_reg[2], shift_reg[1], shift_reg[0]};
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tdm_deframer_1_4.sv
// Directed bench for tdm_deframer_1_4 (WIDTH=8): inputs driven on negedge, outputs checked on negedge.
module tb_tdm_deframer_1_4;
    logic        clk = 1'b0;
    logic        rst, i, in_valid, frame_start, out_ready;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid, busy, overflow, sync_err;

    int tests = 0;
    int fails = 0;

    tdm_deframer_1_4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .frame_start(frame_start),
        .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow(overflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic drive_bit(input logic b, input logic fs, input logic v);
        @(negedge clk);
        i = b; frame_start = fs; in_valid = v;
    endtask

    task automatic idle();
        drive_bit(1'b0, 1'b0, 1'b0);
    endtask

    // Bit k goes to channel k%4, bit 7-k/4; f packs {ch3,ch2,ch1,ch0}.
    function automatic logic frame_bit(input logic [31:0] f, input int k);
        return f[(k % 4) * 8 + 7 - k / 4];
    endfunction

    task automatic send_frame(input logic [31:0] f);
        for (int k = 0; k < 32; k++) drive_bit(frame_bit(f, k), k == 0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({sel, out_data, out_valid, busy, overflow, sync_err} !== 38'd0) begin
            fails++;
            $display("FAIL reset_state: got sel=%0d data=%h v=%b busy=%b ovf=%b serr=%b, want all 0",
                     sel, out_data, out_valid, busy, overflow, sync_err);
        end
    endtask

    task automatic test_basic();
        logic [31:0] f = 32'h01FF3CA5;
        logic sel_ok = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            drive_bit(frame_bit(f, k), k == 0, 1'b1);
            if (sel !== 2'(k % 4)) sel_ok = 1'b0;
            if (k == 31) begin
                tests++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_busy: got busy=%b v=%b, want busy=1 v=0", busy, out_valid);
                end
            end
        end
        tests++;
        if (!sel_ok) begin
            fails++;
            $display("FAIL basic_sel_seq: got out-of-order sel, want k%%4");
        end
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h01FF3CA5 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_out: got v=%b data=%h busy=%b, want v=1 data=01ff3ca5 busy=0",
                     out_valid, out_data, busy);
        end
        idle();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] f = 32'h01FF3CA5;
        logic hold_ok = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            drive_bit(frame_bit(f, k), k == 0, 1'b1);
            if (k % 5 == 4) begin
                for (int g = 0; g < 3; g++) begin
                    idle();
                    if (sel !== 2'((k + 1) % 4) || busy !== 1'b1 || out_valid !== 1'b0) hold_ok = 1'b0;
                end
            end
        end
        tests++;
        if (!hold_ok) begin
            fails++;
            $display("FAIL gaps_hold: got sel/busy moving in gaps, want held");
        end
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h01FF3CA5) begin
            fails++;
            $display("FAIL gaps_out: got v=%b data=%h, want v=1 data=01ff3ca5", out_valid, out_data);
        end
        idle();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        send_frame(32'h44332211);
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_first: got v=%b data=%h ovf=%b, want v=1 data=44332211 ovf=0",
                     out_valid, out_data, overflow);
        end
        send_frame(32'h88776655);
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drop: got v=%b data=%h ovf=%b, want v=1 data=44332211 ovf=1",
                     out_valid, out_data, overflow);
        end
        out_ready = 1'b1;
        idle();
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: got v=%b ovf=%b, want v=0 ovf=1", out_valid, overflow);
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) drive_bit(frame_bit(32'h44332211, k), k == 0, 1'b1);
        idle();
        tests++;
        if (sync_err !== 1'b0 || out_valid !== 1'b0 || sel !== 2'd2) begin
            fails++;
            $display("FAIL sync_partial: got serr=%b v=%b sel=%0d, want serr=0 v=0 sel=2",
                     sync_err, out_valid, sel);
        end
        send_frame(32'h01FF3CA5);
        idle();
        tests++;
        if (sync_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h01FF3CA5) begin
            fails++;
            $display("FAIL sync_out: got serr=%b v=%b data=%h, want serr=1 v=1 data=01ff3ca5",
                     sync_err, out_valid, out_data);
        end
        idle();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL sync_extra: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) drive_bit(frame_bit(32'h88776655, k), k == 0, 1'b1);
        @(negedge clk);
        rst = 1'b1; i = 1'b1; in_valid = 1'b1; frame_start = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        tests++;
        if ({sel, out_data, out_valid, busy, overflow, sync_err} !== 38'd0) begin
            fails++;
            $display("FAIL midrst_state: got sel=%0d data=%h v=%b busy=%b ovf=%b serr=%b, want all 0",
                     sel, out_data, out_valid, busy, overflow, sync_err);
        end
        send_frame(32'h44332211);
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || sync_err !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL midrst_frame: got v=%b data=%h serr=%b ovf=%b, want v=1 data=44332211 serr=0 ovf=0",
                     out_valid, out_data, sync_err, overflow);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        send_frame(32'h44332211);
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            fails++;
            $display("FAIL b2b_first: got v=%b data=%h, want v=1 data=44332211", out_valid, out_data);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            drive_bit(frame_bit(32'h01FF3CA5, k), k == 0, 1'b1);
            if (k == 31) out_ready = 1'b1;
        end
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h01FF3CA5 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: got v=%b data=%h ovf=%b, want v=1 data=01ff3ca5 ovf=0",
                     out_valid, out_data, overflow);
        end
        idle();
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got v=%b ovf=%b, want v=0 ovf=0", out_valid, overflow);
        end
    endtask

    initial begin
        rst = 1'b1; i = 1'b0; in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_sync_err();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
